next_addr_logic: RTL and testbench

- Microsequencer next-address logic for the multicore processor's control unit.
- Each cycle it selects the next microinstruction address from one of three sources:
  - the control-store next-address field (na),
  - the opcode-derived address (ir),
  - a fixed skip address for a not-taken JMPNZ.
- The selected address is registered as the micro-program counter that addresses the control store.
- A combinational copy of the selection is also exported for look-ahead.

---
 rtl/ctrl_pkg.sv | 15 +
 rtl/next_addr_mux.sv | 26 ++
 rtl/next_addr_logic.sv | 49 ++++
 tb/tb_next_addr_logic.sv | 115 +++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared micro-address constants for the control unit
package ctrl_pkg;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] uaddr_t;

    localparam uaddr_t FETCH1  = 5'd0;
    localparam uaddr_t FETCH2  = 5'd1;
    localparam uaddr_t JMPNZY1 = 5'd10;
    localparam uaddr_t JMPNZN1 = 5'd13;
    localparam uaddr_t SUB1    = 5'd19;
    localparam uaddr_t LOAD1   = 5'd21;
    localparam uaddr_t LOAD2   = 5'd22;
    localparam uaddr_t LOAD3   = 5'd23;
endpackage

// File: rtl/next_addr_mux.sv
// rtl/next_addr_mux.sv - combinational micro-address source select
module next_addr_mux
    import ctrl_pkg::*;
#(
    parameter int                          ADDR_W          = ctrl_pkg::ADDR_W,
    parameter logic [ctrl_pkg::ADDR_W-1:0] JMPNZ_ADDR      = ctrl_pkg::JMPNZY1,
    parameter logic [ctrl_pkg::ADDR_W-1:0] JMPNZ_SKIP_ADDR = ctrl_pkg::JMPNZN1
) (
    input  logic              br,
    input  logic              z,
    input  logic [ADDR_W-1:0] ir,
    input  logic [ADDR_W-1:0] na,
    output logic [ADDR_W-1:0] next_addr
);

    // na is only read on the br=0 branch so an undriven field during dispatch cannot leak
    always_comb begin
        next_addr = ir;
        if (!br) begin
            next_addr = na;
        end else if ((ir == JMPNZ_ADDR) && z) begin
            next_addr = JMPNZ_SKIP_ADDR;
        end
    end

endmodule

// File: rtl/next_addr_logic.sv
// rtl/next_addr_logic.sv - microsequencer next-address select and micro-PC register
module next_addr_logic
    import ctrl_pkg::*;
#(
    parameter int                          ADDR_W          = ctrl_pkg::ADDR_W,
    parameter logic [ctrl_pkg::ADDR_W-1:0] FETCH1_ADDR     = ctrl_pkg::FETCH1,
    parameter logic [ctrl_pkg::ADDR_W-1:0] JMPNZ_ADDR      = ctrl_pkg::JMPNZY1,
    parameter logic [ctrl_pkg::ADDR_W-1:0] JMPNZ_SKIP_ADDR = ctrl_pkg::JMPNZN1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              z,
    input  logic [ADDR_W-1:0] ir,
    input  logic [ADDR_W-1:0] na,
    input  logic              br,
    output logic [ADDR_W-1:0] next_addr,
    output logic [ADDR_W-1:0] out
);

    logic [ADDR_W-1:0] out_d;
    logic [ADDR_W-1:0] out_q;

    next_addr_mux #(
        .ADDR_W          (ADDR_W),
        .JMPNZ_ADDR      (JMPNZ_ADDR),
        .JMPNZ_SKIP_ADDR (JMPNZ_SKIP_ADDR)
    ) u_mux (
        .br        (br),
        .z         (z),
        .ir        (ir),
        .na        (na),
        .next_addr (next_addr)
    );

    // Reset wins over every selection input so the sequencer always restarts at fetch
    always_comb begin
        out_d = next_addr;
        if (!rst_n) begin
            out_d = FETCH1_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_next_addr_logic.sv
// tb/tb_next_addr_logic.sv - directed self-checking bench for next_addr_logic
module tb_next_addr_logic;

    logic       clk;
    logic       rst_n;
    logic       z;
    logic [4:0] ir;
    logic [4:0] na;
    logic       br;
    logic [4:0] next_addr;
    logic [4:0] out;

    int pass_cnt  = 0;
    int check_cnt = 0;

    next_addr_logic dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .z         (z),
        .ir        (ir),
        .na        (na),
        .br        (br),
        .next_addr (next_addr),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic zz,
                         input logic [4:0] i, input logic [4:0] n);
        @(negedge clk);
        rst_n = r;
        br    = b;
        z     = zz;
        ir    = i;
        na    = n;
        #1;
    endtask

    task automatic tick_check(input string tag, input logic [4:0] exp);
        @(posedge clk);
        #1;
        check(tag, out, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        br    = 1'b1;
        z     = 1'b0;
        ir    = 5'd21;
        na    = 5'd31;

        tick_check("reset_edge1", 5'd0);
        check("reset_comb_na", next_addr, 5'd21);
        tick_check("reset_edge2", 5'd0);

        drive(1'b1, 1'b0, 1'b0, 5'd21, 5'd1);
        tick_check("release_na1", 5'd1);

        drive(1'b1, 1'b0, 1'b0, 5'd3, 5'd0);
        tick_check("seq_na0", 5'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd3, 5'd1);
        tick_check("seq_na1", 5'd1);

        drive(1'b1, 1'b1, 1'b0, 5'd21, 5'd31);
        check("load1_comb", next_addr, 5'd21);
        tick_check("load1", 5'd21);
        drive(1'b1, 1'b0, 1'b0, 5'd21, 5'd22);
        tick_check("load2", 5'd22);
        drive(1'b1, 1'b0, 1'b0, 5'd21, 5'd23);
        tick_check("load3", 5'd23);
        drive(1'b1, 1'b0, 1'b0, 5'd21, 5'd0);
        tick_check("load_fetch", 5'd0);

        drive(1'b1, 1'b1, 1'b0, 5'd19, 5'd31);
        check("dispatch_comb", next_addr, 5'd19);
        tick_check("dispatch_sub1", 5'd19);

        drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd31);
        tick_check("jmpnz_z0", 5'd10);
        drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd31);
        check("jmpnz_z1_comb", next_addr, 5'd13);
        tick_check("jmpnz_z1", 5'd13);
        drive(1'b1, 1'b0, 1'b1, 5'd10, 5'd11);
        tick_check("jmpnz_br0", 5'd11);

        drive(1'b1, 1'b1, 1'b1, 5'd18, 5'd4);
        tick_check("ir18_z1", 5'd18);
        drive(1'b1, 1'b1, 1'b0, 5'd18, 5'd4);
        tick_check("ir18_z0", 5'd18);

        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd22);
        tick_check("pre_reset_22", 5'd22);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd23);
        check("midreset_comb", next_addr, 5'd23);
        tick_check("midreset", 5'd0);

        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd1);
        tick_check("post_reset", 5'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
